// File: rtl/pio_edge_input_pkg.sv
// Shared constants for the edge-capturing input PIO: register addresses and
// the encodings used by the EDGE_TYPE and IRQ_MODE parameters.
package pio_edge_input_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   localparam int IRQ_LEVEL = 0;
   localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain followed by a stability counter that only
// accepts a new level after it has been seen for DEBOUNCE_CYCLES cycles.
module pio_debounce_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1,
   parameter int RESET_LEVEL     = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din_i,
   output logic filt_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic RST_BIT = 1'(RESET_LEVEL);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out_s;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   filt_q;
   logic                   filt_d;

   assign sync_out_s = sync_q[SYNC_STAGES-1];
   assign filt_o     = filt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RST_BIT}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      end
   end

   // Any return to the accepted level restarts the stability count.
   always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (sync_out_s == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         filt_d = sync_out_s;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         filt_q <= RST_BIT;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

endmodule

// File: rtl/pio_edge_input.sv
// Avalon-MM input PIO: debounced inputs, edge capture with write-1-to-clear,
// interrupt mask and a registered one-cycle-latency read path.
module pio_edge_input
   import pio_edge_input_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1,
   parameter int EDGE_TYPE       = 1,
   parameter int IRQ_MODE        = 1,
   parameter int RESET_LEVEL     = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic RST_BIT = 1'(RESET_LEVEL);

   logic [WIDTH-1:0] filt_s;
   logic [WIDTH-1:0] filt_prev_q;
   logic [WIDTH-1:0] detect_s;
   logic [WIDTH-1:0] clear_s;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] edge_d;
   logic [31:0]      rdata_q;
   logic [31:0]      rdata_d;
   logic [31:0]      filt_ext_s;
   logic [31:0]      mask_ext_s;
   logic [31:0]      edge_ext_s;
   logic             wr_s;
   logic             unused_wdata_s;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_LEVEL    (RESET_LEVEL)
      ) u_bit (
         .clk    (clk),
         .reset_n(reset_n),
         .din_i  (in_port[i]),
         .filt_o (filt_s[i])
      );
   end

   assign wr_s           = chipselect & ~write_n;
   assign unused_wdata_s = ^writedata;
   assign readdata       = rdata_q;

   always_comb begin
      filt_ext_s = 32'd0;
      mask_ext_s = 32'd0;
      edge_ext_s = 32'd0;
      filt_ext_s[WIDTH-1:0] = filt_s;
      mask_ext_s[WIDTH-1:0] = mask_q;
      edge_ext_s[WIDTH-1:0] = edge_q;

      case (EDGE_TYPE)
         EDGE_RISING:  detect_s = filt_s & ~filt_prev_q;
         EDGE_FALLING: detect_s = ~filt_s & filt_prev_q;
         EDGE_ANY:     detect_s = filt_s ^ filt_prev_q;
         default:      detect_s = filt_s ^ filt_prev_q;
      endcase

      if (wr_s && (address == ADDR_MASK)) begin
         mask_d = writedata[WIDTH-1:0];
      end else begin
         mask_d = mask_q;
      end

      if (wr_s && (address == ADDR_EDGE)) begin
         clear_s = writedata[WIDTH-1:0];
      end else begin
         clear_s = '0;
      end

      // A detect in the same cycle as a clear of that bit keeps the bit set.
      if (IRQ_MODE == IRQ_EDGE) begin
         edge_d = (edge_q & ~clear_s) | detect_s;
      end else begin
         edge_d = '0;
      end

      case (address)
         ADDR_DATA: rdata_d = filt_ext_s;
         ADDR_RSVD: rdata_d = 32'd0;
         ADDR_MASK: rdata_d = mask_ext_s;
         ADDR_EDGE: rdata_d = edge_ext_s;
         default:   rdata_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_prev_q <= {WIDTH{RST_BIT}};
         mask_q      <= '0;
         edge_q      <= '0;
         rdata_q     <= 32'd0;
      end else begin
         filt_prev_q <= filt_s;
         mask_q      <= mask_d;
         edge_q      <= edge_d;
         rdata_q     <= rdata_d;
      end
   end

   assign irq = (IRQ_MODE == IRQ_EDGE) ? |(edge_q & mask_q) : |(filt_s & mask_q);

endmodule
